// File: rtl/br_pkg.sv
// Shared widths and the queued write-back record for the register-bank writer.
package br_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NREG_DEF = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] dw;
  } br_wb_t;
endpackage

// File: rtl/br_wq_fifo.sv
// In-order circular write queue; ent[] is age-ordered (ent[0] = head, oldest).
module br_wq_fifo
  import br_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  br_wb_t               din,
  input  logic                 pop,
  output br_wb_t               head,
  output logic [CW-1:0]        count,
  output br_wb_t [DEPTH-1:0]   ent
);
  br_wb_t        mem [DEPTH];
  logic [PW-1:0] rd, wr;

  // Storage needs no reset: nothing is visible beyond count.
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i] = mem[rd + PW'(i)];
  end
endmodule

// File: rtl/br_escritor.sv
// Register-bank write-back client: RR arbitration of ALU/mem results into an
// in-order queue drained to WA/WE/DW. Define BR_FWD_EN for queue forwarding.
module br_escritor
  import br_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int NREG  = NREG_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_wa,
  input  logic [DATA_W-1:0] alu_dw,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_dw,
  input  logic              wr_hold,
  output logic [ADDR_W-1:0] WA,
  output logic              WE,
  output logic [DATA_W-1:0] DW,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data,
  output logic [CW-1:0]     pend_count,
  output logic              err_addr
);
  logic               last_alu, space, contend;
  logic               alu_fire, mem_fire, fire, legal, push, nonempty;
  br_wb_t             sel, head;
  br_wb_t [DEPTH-1:0] ent;
  logic [CW-1:0]      count;

  // Full blocks pushes even when a pop frees a slot on the same edge.
  assign space     = count < CW'(DEPTH);
  assign contend   = alu_valid && mem_valid;
  assign alu_ready = space && !(contend && last_alu);
  assign mem_ready = space && !(contend && !last_alu);
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign fire      = alu_fire || mem_fire;

  always_comb begin
    sel    = '0;
    sel.wa = alu_fire ? alu_wa : mem_wa;
    sel.dw = alu_fire ? alu_dw : mem_dw;
  end

  // Out-of-range destinations still handshake but are dropped.
  assign legal = int'(sel.wa) < NREG;
  assign push  = fire && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_alu <= 1'b1;
      err_addr <= 1'b0;
    end else begin
      if (fire)           last_alu <= alu_fire;
      if (fire && !legal) err_addr <= 1'b1;
    end
  end

  br_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sel),
    .pop   (WE),
    .head  (head),
    .count (count),
    .ent   (ent)
  );

  assign nonempty   = count != '0;
  assign WE         = nonempty && !wr_hold;
  assign WA         = nonempty ? head.wa : '0;
  assign DW         = nonempty ? head.dw : '0;
  assign pend_count = count;

`ifdef BR_FWD_EN
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && ent[i].wa == RA1) begin
        byp1_hit  = 1'b1;
        byp1_data = ent[i].dw;
      end
      if (CW'(i) < count && ent[i].wa == RA2) begin
        byp2_hit  = 1'b1;
        byp2_data = ent[i].dw;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{RA1, RA2, ent};
  assign byp1_hit   = 1'b0;
  assign byp2_hit   = 1'b0;
  assign byp1_data  = '0;
  assign byp2_data  = '0;
`endif
endmodule
